hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter MEM_LAT, default 1, load-use stall cycles (legal 1..8).
REQ-003 Parameter PERF_W, default 16, width of the performance counters.
REQ-004 Reset is asynchronous and active-low; the block uses a single clock.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 id_rs, id_rt  in  REG_AW each  source registers of the instruction in IF/ID.
REQ-008 id_valid  in  1  IF/ID holds a real instruction.
REQ-009 ex_rs, ex_rt  in  REG_AW each  source registers in ID/EX.
REQ-010 ex_rd  in  REG_AW  destination in ID/EX, after the RegDst mux.
REQ-011 ex_memread, ex_regwrite  in  1 each  ID/EX control bits.
REQ-012 mem_rd, mem_regwrite  in  REG_AW, 1  EX/MEM destination and write enable.
REQ-013 wb_rd, wb_regwrite  in  REG_AW, 1  MEM/WB destination and write enable.
REQ-014 branch_taken  in  1  Branch AND Z_flag from EX/MEM.
REQ-015 pc_write, ifid_write  out  1 each  enable for the PC and the IF/ID buffer.
REQ-016 idex_bubble  out  1  zero all control bits entering ID/EX.
REQ-017 flush_ifid, flush_idex, flush_exmem  out  1 each  clear-to-NOP for each buffer.
REQ-018 fwd_a, fwd_b  out  2 each  ALU operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-019 stall_cnt, flush_cnt  out  PERF_W each  saturating event counters.

Function
REQ-020 The state machine SHALL have two states, RUN and STALL; an internal down-counter scnt is 3 bits wide.
REQ-021 A load-use hazard SHALL be detected when the state is RUN, branch_taken=0, id_valid=1, ex_memread=1, ex_rd!=0, and ex_rd equals id_rs or id_rt.
REQ-022 While a hazard is detected, and in every STALL cycle, the block SHALL drive pc_write=0, ifid_write=0 and idex_bubble=1; otherwise it SHALL drive pc_write=1, ifid_write=1 and idex_bubble=0.
REQ-023 On detection with MEM_LAT>1, the block SHALL go to STALL with scnt=MEM_LAT-1; with MEM_LAT=1 it SHALL stay in RUN.
REQ-024 In STALL, scnt SHALL decrement each cycle and the block SHALL return to RUN on the edge where scnt=1, giving exactly MEM_LAT stall cycles per hazard.
REQ-025 branch_taken=1 SHALL assert flush_ifid, flush_idex and flush_exmem combinationally in the same cycle.
REQ-026 branch_taken=1 SHALL force pc_write=1, ifid_write=1 and idex_bubble=0, and SHALL move STALL to RUN, cancelling the stall.
REQ-027 Branch has priority over a hazard detected in the same cycle.
REQ-028 fwd_a SHALL be 10 if mem_regwrite=1, mem_rd!=0 and mem_rd==ex_rs.
REQ-029 Otherwise fwd_a SHALL be 01 if wb_regwrite=1, wb_rd!=0 and wb_rd==ex_rs; otherwise fwd_a SHALL be 00.
REQ-030 fwd_b SHALL follow REQ-028/029 with ex_rt in place of ex_rs.
REQ-031 The forwarding outputs SHALL be purely combinational and independent of state.
REQ-032 Register 0 SHALL never be forwarded and SHALL never cause a stall.
REQ-033 stall_cnt SHALL increment once per stall cycle and flush_cnt once per branch_taken cycle.
REQ-034 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-035 While rst_n=0: state=RUN, scnt=0, stall_cnt=0, flush_cnt=0, pc_write=0, ifid_write=0, idex_bubble=0, all flush outputs 0.
REQ-036 Forwarding outputs SHALL follow REQ-028/029 even during reset.
REQ-037 Reset asserted mid-STALL SHALL abort the stall immediately.
REQ-038 The first edge after rst_n rises SHALL evaluate in RUN.

Structure
REQ-039 The forwarding-select encodings and the state encoding SHALL live in a shared pipeline package, pipe_pkg.
REQ-040 Forwarding SHALL be one sub-module, fwd_unit, instantiated twice (operands A and B); stall/flush control SHALL stay in hazard_ctrl.

Verification
REQ-041 MEM_LAT=1, ex_memread=1, ex_rd=8, id_rs=8 -> exactly one cycle with pc_write=0 and idex_bubble=1, then pc_write=1; stall_cnt=1.
REQ-042 MEM_LAT=3, same hazard -> exactly 3 stall cycles; state returns to RUN; stall_cnt=3.
REQ-043 MEM_LAT=3, branch_taken=1 in the 2nd stall cycle -> all three flushes=1 and pc_write=1 that cycle, stall ends; flush_cnt=1.
REQ-044 mem_rd=wb_rd=5, both regwrite=1, ex_rs=5, ex_rt=0 -> fwd_a=10, fwd_b=00; repeat with mem_regwrite=0 -> fwd_a=01.
REQ-045 PERF_W=4, 20 consecutive branch_taken cycles -> flush_cnt holds at 15.
REQ-046 Hazard with ex_rd=0, id_rs=0 -> no stall.
REQ-047 rst_n pulsed low mid-STALL -> all counters 0; the next cycle is RUN.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: hazard FSM states and ALU operand forwarding selects.
package pipe_pkg;
    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int SCNT_W = 3;
endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one ALU source; EX/MEM wins over MEM/WB, r0 never forwards.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        sel
);
    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src))
            sel = FWD_EXMEM;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))
            sel = FWD_MEMWB;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and forwarding control for a 5-stage pipeline,
// with saturating stall/flush event counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);
    localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(MEM_LAT - 1);

    state_t            state;
    logic [SCNT_W-1:0] scnt;
    logic              hazard;
    logic              stall;
    logic              unused_ex_regwrite;

    assign unused_ex_regwrite = ex_regwrite;

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .src(ex_rs), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(fwd_a)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .src(ex_rt), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(fwd_b)
    );

    // A taken branch squashes the loading instruction, so it masks detection.
    assign hazard = rst_n && (state == RUN) && !branch_taken && id_valid && ex_memread &&
                    (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
    assign stall  = rst_n && !branch_taken && (hazard || (state == STALL));

    assign pc_write    = rst_n && !stall;
    assign ifid_write  = rst_n && !stall;
    assign idex_bubble = stall;
    assign flush_ifid  = rst_n && branch_taken;
    assign flush_idex  = rst_n && branch_taken;
    assign flush_exmem = rst_n && branch_taken;

    // The detection cycle is the first stall cycle; STALL covers the remaining MEM_LAT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            scnt  <= '0;
        end else if (branch_taken) begin
            state <= RUN;
            scnt  <= '0;
        end else if (state == RUN) begin
            if (hazard && (MEM_LAT > 1)) begin
                state <= STALL;
                scnt  <= SCNT_INIT;
            end
        end else if (scnt == SCNT_W'(1)) begin
            state <= RUN;
            scnt  <= '0;
        end else begin
            scnt <= scnt - SCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + PERF_W'(1);
            if (branch_taken && (flush_cnt != '1))
                flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three DUTs (MEM_LAT=1, MEM_LAT=3, PERF_W=4) on shared inputs,
// expected values queued per step and popped when the outputs are sampled.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
    logic       id_valid = 1'b0, ex_memread = 1'b0, ex_regwrite = 1'b0;
    logic       mem_regwrite = 1'b0, wb_regwrite = 1'b0, branch_taken = 1'b0;

    logic        u1_pcw, u1_ifw, u1_bub, u1_fi, u1_fd, u1_fe;
    logic [1:0]  u1_fa, u1_fb;
    logic [15:0] u1_sc, u1_fc;
    logic        u3_pcw, u3_ifw, u3_bub, u3_fi, u3_fd, u3_fe;
    logic [1:0]  u3_fa, u3_fb;
    logic [15:0] u3_sc, u3_fc;
    logic        u4_pcw, u4_ifw, u4_bub, u4_fi, u4_fd, u4_fe;
    logic [1:0]  u4_fa, u4_fb;
    logic [3:0]  u4_sc, u4_fc;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .PERF_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_valid(id_valid),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken), .pc_write(u1_pcw), .ifid_write(u1_ifw), .idex_bubble(u1_bub),
        .flush_ifid(u1_fi), .flush_idex(u1_fd), .flush_exmem(u1_fe), .fwd_a(u1_fa), .fwd_b(u1_fb),
        .stall_cnt(u1_sc), .flush_cnt(u1_fc));

    hazard_ctrl #(.REG_AW(5), .MEM_LAT(3), .PERF_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_valid(id_valid),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken), .pc_write(u3_pcw), .ifid_write(u3_ifw), .idex_bubble(u3_bub),
        .flush_ifid(u3_fi), .flush_idex(u3_fd), .flush_exmem(u3_fe), .fwd_a(u3_fa), .fwd_b(u3_fb),
        .stall_cnt(u3_sc), .flush_cnt(u3_fc));

    hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .PERF_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_valid(id_valid),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken), .pc_write(u4_pcw), .ifid_write(u4_ifw), .idex_bubble(u4_bub),
        .flush_ifid(u4_fi), .flush_idex(u4_fd), .flush_exmem(u4_fe), .fwd_a(u4_fa), .fwd_b(u4_fb),
        .stall_cnt(u4_sc), .flush_cnt(u4_fc));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow: observed=%0h with no expected entry", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = '0; id_rt = '0; id_valid = 1'b0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
        ex_memread = 1'b0; mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic load_use();
        id_valid = 1'b1; id_rs = 5'd8; ex_rd = 5'd8; ex_memread = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: controls low even with a branch pending, forwarding still live.
        branch_taken = 1'b1; mem_rd = 5'd5; mem_regwrite = 1'b1; ex_rs = 5'd5;
        push("rst_pc_write", 0); push("rst_ifid_write", 0); push("rst_bubble", 0);
        push("rst_flush_ifid", 0); push("rst_flush_idex", 0); push("rst_flush_exmem", 0);
        push("rst_fwd_a", 32'(FWD_EXMEM)); push("rst_stall_cnt", 0); push("rst_flush_cnt", 0);
        @(negedge clk); @(negedge clk);
        chk(32'(u1_pcw)); chk(32'(u1_ifw)); chk(32'(u1_bub));
        chk(32'(u1_fi)); chk(32'(u1_fd)); chk(32'(u1_fe));
        chk(32'(u1_fa)); chk(32'(u1_sc)); chk(32'(u1_fc));

        cyc(); rst_n = 1'b1; clr();
        push("run_pc_write", 1); push("run_ifid_write", 1); push("run_bubble", 0);
        push("run_state", 32'(RUN)); push("run_fwd_a", 32'(FWD_RF));
        @(negedge clk);
        chk(32'(u1_pcw)); chk(32'(u1_ifw)); chk(32'(u1_bub)); chk(32'(u3.state)); chk(32'(u1_fa));

        // Load-use hazard: one stall on MEM_LAT=1, three on MEM_LAT=3.
        cyc(); load_use();
        push("lat1_pc_write", 0); push("lat1_ifid_write", 0); push("lat1_bubble", 1); push("lat3_bubble", 1);
        @(negedge clk);
        chk(32'(u1_pcw)); chk(32'(u1_ifw)); chk(32'(u1_bub)); chk(32'(u3_bub));

        cyc(); ex_memread = 1'b0;
        push("lat1_resume", 1); push("lat1_stall_cnt", 1); push("lat3_s2_pc_write", 0);
        push("lat3_s2_bubble", 1); push("lat3_s2_state", 32'(STALL));
        @(negedge clk);
        chk(32'(u1_pcw)); chk(32'(u1_sc)); chk(32'(u3_pcw)); chk(32'(u3_bub)); chk(32'(u3.state));

        cyc();
        push("lat3_s3_pc_write", 0); push("lat3_s3_stall_cnt", 2);
        @(negedge clk);
        chk(32'(u3_pcw)); chk(32'(u3_sc));

        cyc();
        push("lat3_resume", 1); push("lat3_stall_cnt", 3); push("lat3_state", 32'(RUN));
        push("lat1_stall_cnt_hold", 1); push("p4_stall_cnt", 1);
        @(negedge clk);
        chk(32'(u3_pcw)); chk(32'(u3_sc)); chk(32'(u3.state)); chk(32'(u1_sc)); chk(32'(u4_sc));

        // Branch in the 2nd stall cycle cancels the stall.
        cyc(); load_use();
        cyc(); ex_memread = 1'b0; branch_taken = 1'b1;
        push("br_flush_ifid", 1); push("br_flush_idex", 1); push("br_flush_exmem", 1);
        push("br_pc_write", 1); push("br_bubble", 0);
        @(negedge clk);
        chk(32'(u3_fi)); chk(32'(u3_fd)); chk(32'(u3_fe)); chk(32'(u3_pcw)); chk(32'(u3_bub));

        cyc(); branch_taken = 1'b0;
        push("br_after_pc_write", 1); push("br_after_state", 32'(RUN));
        push("br_flush_cnt", 1); push("br_stall_cnt", 4);
        @(negedge clk);
        chk(32'(u3_pcw)); chk(32'(u3.state)); chk(32'(u3_fc)); chk(32'(u3_sc));

        // Branch and hazard together: branch wins.
        cyc(); load_use(); branch_taken = 1'b1;
        push("prio_pc_write", 1); push("prio_bubble", 0); push("prio_flush_ifid", 1);
        @(negedge clk);
        chk(32'(u3_pcw)); chk(32'(u3_bub)); chk(32'(u3_fi));

        cyc(); clr();
        push("prio_after_pc_write", 1); push("prio_stall_cnt", 4); push("prio_flush_cnt", 2);
        @(negedge clk);
        chk(32'(u3_pcw)); chk(32'(u3_sc)); chk(32'(u3_fc));

        // Forwarding priority and register 0.
        cyc(); mem_rd = 5'd5; wb_rd = 5'd5; mem_regwrite = 1'b1; wb_regwrite = 1'b1; ex_rs = 5'd5; ex_rt = 5'd0;
        push("fwd_exmem_a", 32'(FWD_EXMEM)); push("fwd_rt0_b", 32'(FWD_RF));
        @(negedge clk);
        chk(32'(u1_fa)); chk(32'(u1_fb));

        cyc(); mem_regwrite = 1'b0;
        push("fwd_memwb_a", 32'(FWD_MEMWB));
        @(negedge clk);
        chk(32'(u1_fa));

        cyc(); mem_regwrite = 1'b1; ex_rs = 5'd7; ex_rt = 5'd5;
        push("fwd_none_a", 32'(FWD_RF)); push("fwd_exmem_b", 32'(FWD_EXMEM));
        @(negedge clk);
        chk(32'(u1_fa)); chk(32'(u1_fb));

        cyc(); mem_rd = '0; wb_rd = '0; ex_rs = '0; ex_rt = '0;
        push("fwd_r0_a", 32'(FWD_RF)); push("fwd_r0_b", 32'(FWD_RF));
        @(negedge clk);
        chk(32'(u1_fa)); chk(32'(u1_fb));

        // Register 0 and invalid IF/ID never stall; a match on rt does.
        cyc(); clr(); id_valid = 1'b1; ex_memread = 1'b1;
        push("r0_pc_write", 1); push("r0_bubble", 0);
        @(negedge clk);
        chk(32'(u3_pcw)); chk(32'(u3_bub));

        cyc(); id_valid = 1'b0; id_rt = 5'd8; ex_rd = 5'd8;
        push("novalid_pc_write", 1);
        @(negedge clk);
        chk(32'(u3_pcw));

        cyc(); id_valid = 1'b1; id_rs = 5'd3;
        push("rt_bubble", 1);
        @(negedge clk);
        chk(32'(u1_bub));

        cyc(); clr();
        cyc();
        cyc();
        push("rt_stall_cnt", 7); push("rt_resume", 1); push("rt_lat1_stall_cnt", 3);
        @(negedge clk);
        chk(32'(u3_sc)); chk(32'(u3_pcw)); chk(32'(u1_sc));

        // Saturation of a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            cyc(); branch_taken = 1'b1;
        end
        cyc(); branch_taken = 1'b0;
        push("sat_flush_cnt4", 15); push("flush_cnt16", 22);
        @(negedge clk);
        chk(32'(u4_fc)); chk(32'(u1_fc));

        // Reset mid-STALL aborts immediately.
        cyc(); load_use();
        cyc(); ex_memread = 1'b0;
        push("mid_stall_bubble", 1);
        @(negedge clk);
        chk(32'(u3_bub));
        #1 rst_n = 1'b0;
        push("mrst_stall_cnt", 0); push("mrst_flush_cnt", 0); push("mrst_pc_write", 0); push("mrst_state", 32'(RUN));
        #1;
        chk(32'(u3_sc)); chk(32'(u3_fc)); chk(32'(u3_pcw)); chk(32'(u3.state));

        cyc(); rst_n = 1'b1;
        push("post_rst_pc_write", 1); push("post_rst_bubble", 0); push("post_rst_state", 32'(RUN));
        @(negedge clk);
        chk(32'(u3_pcw)); chk(32'(u3_bub)); chk(32'(u3.state));

        cyc();
        push("post_rst_pc_write2", 1); push("post_rst_stall_cnt", 0);
        @(negedge clk);
        chk(32'(u3_pcw)); chk(32'(u3_sc));

        checks++;
        assert (sbq.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover: observed=%0d expected=0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
